fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and drives the word index into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit stalls and branch/jump redirects from EX, including flushing the wrong-path instruction.

---
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly in front of a combinational
// instruction memory. Owns the program counter, drives the word index into
// the memory, and captures the returned instruction into the IF/ID pipeline
// register for decode. Handles hazard stalls and EX-resolved redirects
// (taken branch / JAL / JALR), flushing the wrong-path instruction.
//
// Parameters:
//   RESET_PC  byte address loaded into the PC on reset
//   ADDR_W    instruction-memory word-index width
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   stall_i        in   hazard stall: hold PC and IF/ID
//   redirect_i     in   redirect request from EX (beats stall_i)
//   redirect_pc_i  in   redirect target byte address (low 2 bits ignored)
//   imem_addr_o    out  word index to instruction memory = pc[ADDR_W+1:2]
//   imem_instr_i   in   instruction returned combinationally for imem_addr_o
//   pc_o           out  current fetch PC
//   if_id_pc_o     out  PC of the instruction held in IF/ID
//   if_id_pc4_o    out  if_id_pc_o + 4 (link value for JAL/JALR)
//   if_id_instr_o  out  instruction held in IF/ID
//   if_id_valid_o  out  IF/ID holds a real instruction (0 = bubble)
//
// Optional feature, macro FETCH_PERF_CNT_EN:
//   fetch_cnt_o    out  count of normal fetches (wraps modulo 2^32)
//   flush_cnt_o    out  count of redirect edges (wraps modulo 2^32)
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_instr_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       if_id_pc_o,
    output logic [31:0]       if_id_pc4_o,
    output logic [31:0]       if_id_instr_o,
    output logic              if_id_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    // ADDI x0, x0, 0 -- what a flushed or reset IF/ID slot decodes as.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // IF/ID occupancy: BUBBLE after reset/redirect, RUN after a normal fetch.
    localparam logic [0:0] ST_BUBBLE = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [31:0] pc_reg,       pc_next;
    logic [31:0] if_pc_reg,    if_pc_next;
    logic [31:0] if_pc4_reg,   if_pc4_next;
    logic [31:0] if_instr_reg, if_instr_next;
    logic [0:0]  state_reg,    state_next;
    logic [31:0] pc_plus4;
    logic        do_fetch;

    // Target alignment drops the low two bits on purpose.
    logic        unused_target_bits;
    assign unused_target_bits = ^redirect_pc_i[1:0];

    // All PC arithmetic wraps modulo 2^32.
    assign pc_plus4 = pc_reg + 32'd4;

    // A normal fetch happens only when neither redirect nor stall is active.
    assign do_fetch = !redirect_i && !stall_i;

    // ------------------------------------------------------------------
    // Next-state logic. Redirect has the highest priority, then stall.
    // On a redirect the IF/ID pc fields still take the current pc so the
    // flushed slot carries a meaningful (if unused) address.
    // ------------------------------------------------------------------
    always_comb begin
        pc_next       = pc_reg;
        if_pc_next    = if_pc_reg;
        if_pc4_next   = if_pc4_reg;
        if_instr_next = if_instr_reg;
        state_next    = state_reg;

        if (redirect_i) begin
            pc_next       = {redirect_pc_i[31:2], 2'b00};
            if_pc_next    = pc_reg;
            if_pc4_next   = pc_plus4;
            if_instr_next = NOP_INSTR;
            state_next    = ST_BUBBLE;
        end else if (!stall_i) begin
            pc_next       = pc_plus4;
            if_pc_next    = pc_reg;
            if_pc4_next   = pc_plus4;
            if_instr_next = imem_instr_i;
            state_next    = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg       <= RESET_PC;
            if_pc_reg    <= 32'h0000_0000;
            if_pc4_reg   <= 32'h0000_0004;
            if_instr_reg <= NOP_INSTR;
            state_reg    <= ST_BUBBLE;
        end else begin
            pc_reg       <= pc_next;
            if_pc_reg    <= if_pc_next;
            if_pc4_reg   <= if_pc4_next;
            if_instr_reg <= if_instr_next;
            state_reg    <= state_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Redirects that override a stall still count as flushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            if (do_fetch) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (redirect_i) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;
`else
    logic unused_do_fetch;
    assign unused_do_fetch = do_fetch;
`endif

    // Outputs come straight from registers: no path from stall/redirect.
    // The word index wraps naturally by truncation.
    assign imem_addr_o   = pc_reg[ADDR_W+1:2];
    assign pc_o          = pc_reg;
    assign if_id_pc_o    = if_pc_reg;
    assign if_id_pc4_o   = if_pc4_reg;
    assign if_id_instr_o = if_instr_reg;
    assign if_id_valid_o = (state_reg == ST_RUN);

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage: directed vector table, hand-written
// wrap/reset sequences, and a randomized run against a behavioural model.
// Define FETCH_PERF_CNT_EN to also check the performance counters.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic        reset_n, stall, redirect;
    logic [31:0] target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr, pc, if_pc, if_pc4, if_instr;
    logic        valid;

    // Wrap DUT (RESET_PC = 0xFFFF_FFFC)
    logic        w_reset_n, w_stall, w_redirect;
    logic [31:0] w_target;
    logic [7:0]  w_imem_addr;
    logic [31:0] w_imem_instr, w_pc, w_if_pc, w_if_pc4, w_if_instr;
    logic        w_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt, w_fetch_cnt, w_flush_cnt;
`endif

    logic [31:0] mem [256];
    assign imem_instr   = mem[imem_addr];
    assign w_imem_instr = mem[w_imem_addr];

    fetch_stage #(.RESET_PC(32'h0000_0000), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(target), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .pc_o(pc), .if_id_pc_o(if_pc), .if_id_pc4_o(if_pc4),
        .if_id_instr_o(if_instr), .if_id_valid_o(valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt_o(fetch_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(8)) dut_wrap (
        .clk(clk), .reset_n(w_reset_n), .stall_i(w_stall), .redirect_i(w_redirect),
        .redirect_pc_i(w_target), .imem_addr_o(w_imem_addr), .imem_instr_i(w_imem_instr),
        .pc_o(w_pc), .if_id_pc_o(w_if_pc), .if_id_pc4_o(w_if_pc4),
        .if_id_instr_o(w_if_instr), .if_id_valid_o(w_valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt_o(w_fetch_cnt), .flush_cnt_o(w_flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ADD instruction with rd/rs1 encoding the word number, distinct per word.
    function automatic logic [31:0] add_word(input int k);
        logic [31:0] kk;
        kk = k;
        return 32'h0000_0033 | ((kk & 32'd31) << 7) | (((kk >> 5) & 32'd7) << 15);
    endfunction

    typedef struct packed {
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] e_pc;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vec [13];

    // Behavioural model state
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic        m_valid;
    int          m_fetches, m_flushes;

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0;
        m_fetches = 0; m_flushes = 0;
    endtask

    // One rising edge of the fetch stage, expressed as the architectural rule.
    task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
        if (r) begin
            m_ifpc    = m_pc;
            m_instr   = NOP;
            m_valid   = 1'b0;
            m_pc      = (t / 4) * 4;
            m_flushes = m_flushes + 1;
        end else if (!s) begin
            m_ifpc    = m_pc;
            m_instr   = mem[(m_pc / 4) % 256];
            m_valid   = 1'b1;
            m_pc      = m_pc + 32'd4;
            m_fetches = m_fetches + 1;
        end
    endtask

    task automatic model_compare(input string tag);
        chk({tag, " pc"},    pc,                 m_pc);
        chk({tag, " addr"},  {24'h0, imem_addr}, (m_pc / 4) % 256);
        chk({tag, " ifpc"},  if_pc,              m_ifpc);
        chk({tag, " ifpc4"}, if_pc4,             m_ifpc + 32'd4);
        chk({tag, " instr"}, if_instr,           m_instr);
        chk({tag, " valid"}, {31'h0, valid},     {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, " fetch_cnt"}, fetch_cnt, m_fetches);
        chk({tag, " flush_cnt"}, flush_cnt, m_flushes);
`endif
    endtask

    initial begin
        int tally_fetch;
        int tally_flush;

        for (int k = 0; k < 256; k++) mem[k] = add_word(k);
        reset_n = 1'b1; w_reset_n = 1'b1;
        stall = 1'b0; redirect = 1'b0; target = 32'h0;
        w_stall = 1'b0; w_redirect = 1'b0; w_target = 32'h0;
        #1 reset_n = 1'b0; w_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Reset state, before the first edge
        chk("rst pc",    pc,               32'h0);
        chk("rst addr",  {24'h0, imem_addr}, 32'h0);
        chk("rst ifpc",  if_pc,            32'h0);
        chk("rst ifpc4", if_pc4,           32'h4);
        chk("rst instr", if_instr,         NOP);
        chk("rst valid", {31'h0, valid},   32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst fetch_cnt", fetch_cnt, 32'h0);
        chk("rst flush_cnt", flush_cnt, 32'h0);
`endif

        //          stall redir target        pc            ifpc          instr          valid
        vec[0]  = '{1'b0, 1'b0, 32'h0,      32'h004,      32'h000,      add_word(0),   1'b1};
        vec[1]  = '{1'b0, 1'b0, 32'h0,      32'h008,      32'h004,      add_word(1),   1'b1};
        vec[2]  = '{1'b1, 1'b0, 32'h0,      32'h008,      32'h004,      add_word(1),   1'b1};
        vec[3]  = '{1'b1, 1'b0, 32'h0,      32'h008,      32'h004,      add_word(1),   1'b1};
        vec[4]  = '{1'b1, 1'b0, 32'h0,      32'h008,      32'h004,      add_word(1),   1'b1};
        vec[5]  = '{1'b0, 1'b0, 32'h0,      32'h00C,      32'h008,      add_word(2),   1'b1};
        vec[6]  = '{1'b0, 1'b1, 32'h46,     32'h044,      32'h00C,      NOP,           1'b0};
        vec[7]  = '{1'b0, 1'b0, 32'h0,      32'h048,      32'h044,      add_word(17),  1'b1};
        vec[8]  = '{1'b1, 1'b1, 32'h20,     32'h020,      32'h048,      NOP,           1'b0};
        vec[9]  = '{1'b1, 1'b0, 32'h0,      32'h020,      32'h048,      NOP,           1'b0};
        vec[10] = '{1'b0, 1'b0, 32'h0,      32'h024,      32'h020,      add_word(8),   1'b1};
        vec[11] = '{1'b0, 1'b1, 32'h3FE,    32'h3FC,      32'h024,      NOP,           1'b0};
        vec[12] = '{1'b0, 1'b0, 32'h0,      32'h400,      32'h3FC,      add_word(255), 1'b1};

        tally_fetch = 0;
        tally_flush = 0;
        for (int i = 0; i < 13; i++) begin
            stall    = vec[i].stall;
            redirect = vec[i].redirect;
            target   = vec[i].target;
            if (vec[i].redirect) tally_flush++;
            else if (!vec[i].stall) tally_fetch++;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d pc", i),    pc,                vec[i].e_pc);
            chk($sformatf("vec%0d addr", i),  {24'h0, imem_addr}, (vec[i].e_pc >> 2) & 32'hFF);
            chk($sformatf("vec%0d ifpc", i),  if_pc,             vec[i].e_ifpc);
            chk($sformatf("vec%0d ifpc4", i), if_pc4,            vec[i].e_ifpc + 32'd4);
            chk($sformatf("vec%0d instr", i), if_instr,          vec[i].e_instr);
            chk($sformatf("vec%0d valid", i), {31'h0, valid},    {31'h0, vec[i].e_valid});
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("vec%0d fetch_cnt", i), fetch_cnt, tally_fetch);
            chk($sformatf("vec%0d flush_cnt", i), flush_cnt, tally_flush);
`endif
            $display("vec %0d stall=%0b redir=%0b pc=%h addr=%0d ifpc=%h instr=%h valid=%0b",
                     i, stall, redirect, pc, imem_addr, if_pc, if_instr, valid);
        end
        stall = 1'b0; redirect = 1'b0; target = 32'h0;

        // 32-bit PC wrap on the second instance
        @(negedge clk);
        w_reset_n = 1'b1;
        #1;
        chk("wrap rst pc",   w_pc,                32'hFFFF_FFFC);
        chk("wrap rst addr", {24'h0, w_imem_addr}, 32'd255);
        @(posedge clk);
        #1;
        w_stall = 1'b1;
        chk("wrap pc",    w_pc,                32'h0);
        chk("wrap ifpc4", w_if_pc4,            32'h0);
        chk("wrap ifpc",  w_if_pc,             32'hFFFF_FFFC);
        chk("wrap instr", w_if_instr,          add_word(255));
        chk("wrap valid", {31'h0, w_valid},    32'h1);
        chk("wrap addr",  {24'h0, w_imem_addr}, 32'h0);
        $display("wrap pc=%h ifpc=%h ifpc4=%h valid=%0b", w_pc, w_if_pc, w_if_pc4, w_valid);

        // Randomized run against the model, from a fresh asynchronous reset
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        model_reset();
        model_compare("rnd reset");
        for (int n = 0; n < 300; n++) begin
            stall    = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 5) == 0);
            target   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1023);
            @(posedge clk);
            model_edge(stall, redirect, target);
            #1;
            model_compare($sformatf("rnd%0d", n));
            $display("rnd %0d stall=%0b redir=%0b tgt=%h pc=%h ifpc=%h valid=%0b",
                     n, stall, redirect, target, pc, if_pc, valid);
        end

        // Asynchronous reset while stalled at pc 0x30
        stall = 1'b0; redirect = 1'b1; target = 32'h30;
        @(posedge clk);
        #1;
        redirect = 1'b0; stall = 1'b1;
        @(posedge clk);
        #1;
        chk("midstall pc", pc, 32'h30);
        #2 reset_n = 1'b0;
        #1;
        chk("async pc",    pc,             32'h0);
        chk("async valid", {31'h0, valid}, 32'h0);
        chk("async instr", if_instr,       NOP);
        chk("async ifpc",  if_pc,          32'h0);
        chk("async ifpc4", if_pc4,         32'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("async fetch_cnt", fetch_cnt, 32'h0);
        chk("async flush_cnt", flush_cnt, 32'h0);
`endif
        $display("async reset pc=%h valid=%0b instr=%h", pc, valid, if_instr);
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post5 pc",    pc,             32'd20);
        chk("post5 ifpc",  if_pc,          32'd16);
        chk("post5 valid", {31'h0, valid}, 32'h1);
        chk("post5 instr", if_instr,       mem[4]);
`ifdef FETCH_PERF_CNT_EN
        chk("post5 fetch_cnt", fetch_cnt, 32'd5);
        chk("post5 flush_cnt", flush_cnt, 32'd0);
`endif
        $display("post5 pc=%h ifpc=%h valid=%0b", pc, if_pc, valid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
